// File: rtl/hazard_stall_controller_pkg.sv
// ---------------------------------------------------------------------------
// hazard_stall_controller_pkg
// Shared pipeline-control definitions: FSM state encoding, counter widths,
// default parameter values and the bundle of per-cycle control strobes.
// No ports (package).
// ---------------------------------------------------------------------------
package hazard_stall_controller_pkg;

    // 2-bit FSM state encoding
    localparam logic [1:0] S_RUN      = 2'd0;
    localparam logic [1:0] S_FLUSH    = 2'd1;
    localparam logic [1:0] S_MEM_WAIT = 2'd2;

    // Counter widths
    localparam int FLUSH_CNT_W = 3;   // holds FLUSH_CYCLES-1, up to 6
    localparam int WAIT_CNT_W  = 8;   // memory-wait cycles, up to 255
    localparam int PERF_CNT_W  = 16;  // performance counters

    // Default parameter constants
    localparam int FLUSH_CYCLES_DEFAULT = 2;
    localparam int MEM_TIMEOUT_DEFAULT  = 255;

    // Pipeline control strobes produced each cycle
    typedef struct packed {
        logic pc_freeze;
        logic if_id_freeze;
        logic if_id_flush;
        logic id_ex_bubble;
        logic back_freeze;
    } ctrl_t;

endpackage

// File: rtl/hazard_stall_controller_sat_counter16.sv
// ---------------------------------------------------------------------------
// sat_counter16
// 16-bit up-counter that saturates at all-ones, with a synchronous clear
// that wins over an increment in the same cycle.
// Ports:
//   clk      in   clock
//   rst_n    in   asynchronous active-low reset (count -> 0)
//   clr_i    in   synchronous clear
//   inc_i    in   increment request
//   count_o  out  current count
// ---------------------------------------------------------------------------
module sat_counter16
    import hazard_stall_controller_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr_i,
    input  logic                  inc_i,
    output logic [PERF_CNT_W-1:0] count_o
);

    logic [PERF_CNT_W-1:0] count_q;
    logic [PERF_CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != '1)) begin
            count_d = count_q + PERF_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/hazard_stall_controller.sv
// ---------------------------------------------------------------------------
// hazard_stall_controller
// Pipeline stall/flush sequencer. Combines hazard, taken-branch and
// memory-busy requests into freeze/flush/bubble strobes that act in the
// same cycle as the request, tracks a multi-cycle branch flush, flags a
// sticky memory timeout and keeps stall/flush performance counters.
//
// State table
//   state      | meaning
//   S_RUN      | normal flow; hazards stall, taken branch starts a flush
//   S_FLUSH    | flushing wrong-path fetches, flush counter holds cycles left
//   S_MEM_WAIT | whole pipeline frozen on data memory; flush count preserved
//
// Ports:
//   clk                    in   pipeline clock
//   reset                  in   asynchronous active-low reset
//   i_Sig_Hazard_Detected  in   load-use / RAW stall request
//   i_Sig_Branch_Taken     in   taken branch resolved in EXE
//   i_Sig_Mem_Busy         in   data memory not ready
//   i_Sig_Count_Clear      in   synchronous clear of perf counters
//   o_Sig_PC_Freeze        out  hold PC
//   o_Sig_IF_ID_Freeze     out  hold IF/ID
//   o_Sig_IF_ID_Flush      out  NOP into IF/ID
//   o_Sig_ID_EX_Bubble     out  NOP into ID/EX
//   o_Sig_Back_Freeze      out  hold ID/EX, EX/MEM, MEM/WB
//   o_Sig_Mem_Timeout      out  sticky memory timeout
//   o_Stall_Count          out  saturating hazard-stall cycle count
//   o_Flush_Count          out  saturating taken-branch count
// ---------------------------------------------------------------------------
module hazard_stall_controller
    import hazard_stall_controller_pkg::*;
#(
    parameter int FLUSH_CYCLES = FLUSH_CYCLES_DEFAULT,  // 1..7
    parameter int MEM_TIMEOUT  = MEM_TIMEOUT_DEFAULT    // 1..255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_Sig_Hazard_Detected,
    input  logic                  i_Sig_Branch_Taken,
    input  logic                  i_Sig_Mem_Busy,
    input  logic                  i_Sig_Count_Clear,
    output logic                  o_Sig_PC_Freeze,
    output logic                  o_Sig_IF_ID_Freeze,
    output logic                  o_Sig_IF_ID_Flush,
    output logic                  o_Sig_ID_EX_Bubble,
    output logic                  o_Sig_Back_Freeze,
    output logic                  o_Sig_Mem_Timeout,
    output logic [PERF_CNT_W-1:0] o_Stall_Count,
    output logic [PERF_CNT_W-1:0] o_Flush_Count
);

    localparam logic [FLUSH_CNT_W-1:0] FLUSH_RELOAD = FLUSH_CNT_W'(FLUSH_CYCLES - 1);
    localparam logic [WAIT_CNT_W-1:0]  TIMEOUT_VAL  = WAIT_CNT_W'(MEM_TIMEOUT);

    logic [1:0]             state_q, state_d;
    logic [1:0]             eff_state;
    logic [FLUSH_CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic [WAIT_CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic                   timeout_q, timeout_d;
    ctrl_t                  ctrl;
    logic                   stall_inc;
    logic                   flush_inc;

    // When memory releases in S_MEM_WAIT the cycle behaves as the state the
    // pipeline was in before the wait, so the decision is taken that cycle
    // rather than one cycle later.
    always_comb begin
        eff_state = state_q;
        if (state_q == S_MEM_WAIT) begin
            eff_state = (flush_cnt_q != '0) ? S_FLUSH : S_RUN;
        end
    end

    always_comb begin
        ctrl        = '0;
        state_d     = S_RUN;
        flush_cnt_d = flush_cnt_q;
        stall_inc   = 1'b0;
        flush_inc   = 1'b0;

        if (i_Sig_Mem_Busy) begin
            // EXE is frozen, so branch/hazard will be re-presented later
            ctrl.pc_freeze    = 1'b1;
            ctrl.if_id_freeze = 1'b1;
            ctrl.back_freeze  = 1'b1;
            state_d           = S_MEM_WAIT;
        end else if (i_Sig_Branch_Taken) begin
            ctrl.if_id_flush  = 1'b1;
            ctrl.id_ex_bubble = 1'b1;
            flush_cnt_d       = FLUSH_RELOAD;
            flush_inc         = 1'b1;
            state_d           = (FLUSH_RELOAD != '0) ? S_FLUSH : S_RUN;
        end else if (eff_state == S_FLUSH) begin
            // hazards here belong to wrong-path instructions and are dropped
            ctrl.if_id_flush  = 1'b1;
            ctrl.id_ex_bubble = 1'b1;
            flush_cnt_d       = (flush_cnt_q != '0) ? flush_cnt_q - FLUSH_CNT_W'(1) : '0;
            state_d           = (flush_cnt_d != '0) ? S_FLUSH : S_RUN;
        end else if (i_Sig_Hazard_Detected) begin
            ctrl.pc_freeze    = 1'b1;
            ctrl.if_id_freeze = 1'b1;
            ctrl.id_ex_bubble = 1'b1;
            stall_inc         = 1'b1;
            state_d           = S_RUN;
        end
    end

    always_comb begin
        wait_cnt_d = '0;
        if (i_Sig_Mem_Busy) begin
            wait_cnt_d = (wait_cnt_q == '1) ? wait_cnt_q : wait_cnt_q + WAIT_CNT_W'(1);
        end
        timeout_d = timeout_q | (i_Sig_Mem_Busy && (wait_cnt_d == TIMEOUT_VAL));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_RUN;
            flush_cnt_q <= '0;
            wait_cnt_q  <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            timeout_q   <= timeout_d;
        end
    end

    // Strobes are gated by reset so nothing reaches the pipeline while it is
    // held, even if the request inputs are active.
    assign o_Sig_PC_Freeze    = reset & ctrl.pc_freeze;
    assign o_Sig_IF_ID_Freeze = reset & ctrl.if_id_freeze;
    assign o_Sig_IF_ID_Flush  = reset & ctrl.if_id_flush;
    assign o_Sig_ID_EX_Bubble = reset & ctrl.id_ex_bubble;
    assign o_Sig_Back_Freeze  = reset & ctrl.back_freeze;
    assign o_Sig_Mem_Timeout  = timeout_q;

    sat_counter16 u_stall_cnt (
        .clk     (clk),
        .rst_n   (reset),
        .clr_i   (i_Sig_Count_Clear),
        .inc_i   (stall_inc),
        .count_o (o_Stall_Count)
    );

    sat_counter16 u_flush_cnt (
        .clk     (clk),
        .rst_n   (reset),
        .clr_i   (i_Sig_Count_Clear),
        .inc_i   (flush_inc),
        .count_o (o_Flush_Count)
    );

endmodule

// File: doc/hazard_stall_controller.md
HAZARD_STALL_CONTROLLER -- requirements
Module: hazard_stall_controller

Interface
REQ-001 SHALL have parameter FLUSH_CYCLES, default 2: number of cycles IF/ID flush and ID/EX bubble are held after a taken branch, legal range 1..7.
REQ-002 SHALL have parameter MEM_TIMEOUT, default 255: consecutive memory-wait cycles before the timeout flag sets, legal range 1..255.
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
REQ-004 Ports:
- clk  in  1  pipeline clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- i_Sig_Hazard_Detected  in  1  load-use or RAW stall request from the hazard detection unit.
- i_Sig_Branch_Taken  in  1  taken branch resolved in EXE.
- i_Sig_Mem_Busy  in  1  data memory not ready; whole pipeline must hold.
- i_Sig_Count_Clear  in  1  synchronous clear of the performance counters.
- o_Sig_PC_Freeze  out  1  hold the PC.
- o_Sig_IF_ID_Freeze  out  1  hold the IF/ID register.
- o_Sig_IF_ID_Flush  out  1  load a NOP into IF/ID.
- o_Sig_ID_EX_Bubble  out  1  load a NOP into ID/EX.
- o_Sig_Back_Freeze  out  1  hold ID/EX, EX/MEM and MEM/WB.
- o_Sig_Mem_Timeout  out  1  sticky memory-timeout error.
- o_Stall_Count  out  16  saturating count of hazard-stall cycles.
- o_Flush_Count  out  16  saturating count of taken-branch events.

Function
REQ-005 SHALL implement FSM states S_RUN, S_FLUSH and S_MEM_WAIT. Control outputs are combinational from state and inputs so a stall or flush acts in the same cycle as its request.
REQ-006 Priority in every state, highest first: i_Sig_Mem_Busy, then i_Sig_Branch_Taken, then i_Sig_Hazard_Detected.
REQ-007 Any state with i_Sig_Mem_Busy=1:
- assert o_Sig_PC_Freeze, o_Sig_IF_ID_Freeze and o_Sig_Back_Freeze; deassert flush and bubble;
- next state S_MEM_WAIT;
- ignore branch and hazard inputs, since EXE is frozen and upstream re-presents them.
REQ-008 S_RUN with i_Sig_Branch_Taken=1 and no memory busy:
- assert o_Sig_IF_ID_Flush and o_Sig_ID_EX_Bubble; PC not frozen;
- load flush counter with FLUSH_CYCLES-1;
- next state S_FLUSH if the loaded value is nonzero, else S_RUN.
REQ-009 S_RUN with only i_Sig_Hazard_Detected=1:
- assert o_Sig_PC_Freeze, o_Sig_IF_ID_Freeze and o_Sig_ID_EX_Bubble; remain in S_RUN.
REQ-010 S_FLUSH:
- assert o_Sig_IF_ID_Flush and o_Sig_ID_EX_Bubble and decrement the flush counter;
- ignore hazard (wrong-path instruction);
- a new taken branch reloads the counter with FLUSH_CYCLES-1;
- return to S_RUN when the counter is 0 after decrement.
REQ-011 S_MEM_WAIT:
- increment an 8-bit wait counter each busy cycle;
- when it reaches MEM_TIMEOUT, set o_Sig_Mem_Timeout, which stays set until reset;
- when i_Sig_Mem_Busy=0, clear the wait counter and take the REQ-006 decision that cycle;
- return to S_FLUSH if the flush counter is nonzero, else S_RUN. The flush counter does not change during the wait.
REQ-012 o_Stall_Count SHALL increment on every cycle in which REQ-009 applies. o_Flush_Count SHALL increment on every cycle in which a taken branch is accepted (REQ-008 or REQ-010). Both saturate at 16'hFFFF.
REQ-013 i_Sig_Count_Clear SHALL zero both counters on the next edge and take precedence over an increment in the same cycle.
REQ-014 Freeze and flush SHALL never assert together on the same pipeline register.

Reset
REQ-015 reset=0 SHALL asynchronously force:
- state S_RUN;
- flush counter and wait counter 0;
- o_Sig_Mem_Timeout 0, o_Stall_Count 0, o_Flush_Count 0.
While reset=0 all control outputs are 0.
REQ-016 Reset asserted mid-flush or mid-wait SHALL discard the pending flush and wait. Deassertion is synchronized by the integrating top; the block needs no internal synchronizer.

Structure
REQ-017 State encoding (2-bit), counter widths and default parameter constants SHALL live in the shared pipeline package.
REQ-018 The saturating 16-bit counter with clear SHALL be one sub-module, sat_counter16, instantiated twice.

Verification
REQ-019 Hazard=1 for 3 cycles with no branch or busy -> PC/IF_ID freeze and bubble for exactly 3 cycles; o_Stall_Count=3.
REQ-020 Branch_Taken=1 for 1 cycle with FLUSH_CYCLES=2 -> flush and bubble for 2 cycles, PC never frozen; o_Flush_Count=1; hazard=1 in the second cycle ignored.
REQ-021 Branch taken, then Mem_Busy=1 for 4 cycles in the second flush cycle -> all freezes for 4 cycles, then 1 remaining flush cycle, then S_RUN.
REQ-022 Mem_Busy=1 for 256 cycles with MEM_TIMEOUT=255 -> o_Sig_Mem_Timeout rises after the 255th busy cycle and stays 1 after busy drops; only reset clears it.
REQ-023 Force o_Stall_Count to 16'hFFFE, then hazard for 3 cycles -> count holds at 16'hFFFF; Count_Clear together with a hazard -> 0.
REQ-024 reset=0 asserted asynchronously mid-S_FLUSH -> all outputs 0 immediately; after release, hazard=1 gives a stall, not a flush.
